// File: rtl/fft_bfly_ctrl_if.sv
// Butterfly bundle: sequencer operands, multiplier handshake,
// downstream results and status.
interface fft_bfly_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_r, a_i;
  logic [WIDTH-1:0] b_r, b_i;
  logic [WIDTH-1:0] w_r, w_i;
  logic             mul_en;
  logic             mul_ready;
  logic [WIDTH-1:0] mul_a_r, mul_a_i;
  logic [WIDTH-1:0] mul_b_r, mul_b_i;
  logic [WIDTH-1:0] mul_c_r, mul_c_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y0_r, y0_i;
  logic [WIDTH-1:0] y1_r, y1_i;
  logic             err;
  logic             busy;

  modport master (
    input  in_valid, a_r, a_i, b_r, b_i, w_r, w_i,
    input  mul_ready, mul_c_r, mul_c_i, out_ready,
    output in_ready, mul_en,
    output mul_a_r, mul_a_i, mul_b_r, mul_b_i,
    output out_valid, y0_r, y0_i, y1_r, y1_i,
    output err, busy
  );

  modport slave (
    output in_valid, a_r, a_i, b_r, b_i, w_r, w_i,
    output mul_ready, mul_c_r, mul_c_i, out_ready,
    input  in_ready, mul_en,
    input  mul_a_r, mul_a_i, mul_b_r, mul_b_i,
    input  out_valid, y0_r, y0_i, y1_r, y1_i,
    input  err, busy
  );
endinterface

// File: rtl/fft_bfly_ctrl.sv
// Radix-2 DIT butterfly driving a shared complex multiplier
// through an enable/ready handshake, with abort on timeout.
module fft_bfly_ctrl #(
  parameter int WIDTH   = 16,
  parameter int SCALE   = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_bfly_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WACK  = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_CALC  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [WIDTH:0]   wide_t;

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  word_t      r_ar, r_ai, r_br, r_bi;
  word_t      r_wr, r_wi, r_pr, r_pi;
  word_t      r_y0r, r_y0i, r_y1r, r_y1i;
  logic       r_ov;
  logic       r_err;
  logic       w_rdy;
  logic       w_xfer;
  logic       w_tmo;
  wide_t      w_s0r, w_s0i, w_s1r, w_s1i;

  function automatic word_t fmt(input wide_t s);
    if (SCALE != 0) return s[WIDTH:1];
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
  endfunction

  // ready is forced low while reset is held
  assign w_rdy  = rst_n & (r_state == S_IDLE);
  assign w_xfer = bus.in_valid & w_rdy;
  assign w_tmo  = (r_cnt == 8'(TIMEOUT - 1));

  assign w_s0r = {r_ar[WIDTH-1], r_ar} + {r_pr[WIDTH-1], r_pr};
  assign w_s0i = {r_ai[WIDTH-1], r_ai} + {r_pi[WIDTH-1], r_pi};
  assign w_s1r = {r_ar[WIDTH-1], r_ar} - {r_pr[WIDTH-1], r_pr};
  assign w_s1i = {r_ai[WIDTH-1], r_ai} - {r_pi[WIDTH-1], r_pi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ar    <= '0;
      r_ai    <= '0;
      r_br    <= '0;
      r_bi    <= '0;
      r_wr    <= '0;
      r_wi    <= '0;
      r_pr    <= '0;
      r_pi    <= '0;
      r_y0r   <= '0;
      r_y0i   <= '0;
      r_y1r   <= '0;
      r_y1i   <= '0;
      r_ov    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_xfer) begin
          r_ar    <= bus.a_r;
          r_ai    <= bus.a_i;
          r_br    <= bus.b_r;
          r_bi    <= bus.b_i;
          r_wr    <= bus.w_r;
          r_wi    <= bus.w_i;
          r_state <= S_ISSUE;
        end
        S_ISSUE: if (bus.mul_ready) begin
          r_cnt   <= '0;
          r_state <= S_WACK;
        end
        S_WACK: begin
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (!bus.mul_ready) r_state <= S_WDONE;
          end
        end
        S_WDONE: begin
          if (bus.mul_ready) begin
            r_pr    <= bus.mul_c_r;
            r_pi    <= bus.mul_c_i;
            r_state <= S_CALC;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_CALC: begin
          r_y0r   <= fmt(w_s0r);
          r_y0i   <= fmt(w_s0i);
          r_y1r   <= fmt(w_s1r);
          r_y1i   <= fmt(w_s1i);
          r_ov    <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: if (bus.out_ready) begin
          r_ov    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_rdy;
  assign bus.mul_en    = (r_state == S_ISSUE) & bus.mul_ready;
  assign bus.mul_a_r   = r_wr;
  assign bus.mul_a_i   = r_wi;
  assign bus.mul_b_r   = r_br;
  assign bus.mul_b_i   = r_bi;
  assign bus.out_valid = r_ov;
  assign bus.y0_r      = r_y0r;
  assign bus.y0_i      = r_y0i;
  assign bus.y1_r      = r_y1r;
  assign bus.y1_i      = r_y1i;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// Directed bench: one scaled and one saturating butterfly
// driven in lockstep by a scripted multiplier.
module tb_fft_bfly_ctrl;
  typedef logic [15:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_en1 = 0;
  int   n_en0 = 0;
  word_t hold;

  fft_bfly_ctrl_if #(.WIDTH(16)) if1 ();
  fft_bfly_ctrl_if #(.WIDTH(16)) if0 ();

  fft_bfly_ctrl #(.WIDTH(16), .SCALE(1), .TIMEOUT(8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master)
  );
  fft_bfly_ctrl #(.WIDTH(16), .SCALE(0), .TIMEOUT(8)) u_s0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if1.mul_en) n_en1 <= n_en1 + 1;
    if (if0.mul_en) n_en0 <= n_en0 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input word_t obs,
                     input word_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic v,
                        input word_t ar, ai, br, bi, wr, wi);
    if1.in_valid = v; if0.in_valid = v;
    if1.a_r = ar; if0.a_r = ar;
    if1.a_i = ai; if0.a_i = ai;
    if1.b_r = br; if0.b_r = br;
    if1.b_i = bi; if0.b_i = bi;
    if1.w_r = wr; if0.w_r = wr;
    if1.w_i = wi; if0.w_i = wi;
  endtask

  task automatic set_mul(input logic rdy, input word_t cr, ci);
    if1.mul_ready = rdy; if0.mul_ready = rdy;
    if1.mul_c_r = cr; if0.mul_c_r = cr;
    if1.mul_c_i = ci; if0.mul_c_i = ci;
  endtask

  task automatic set_ordy(input logic r);
    if1.out_ready = r; if0.out_ready = r;
  endtask

  task automatic chk_y(input word_t a0r, a0i, a1r, a1i,
                       input word_t b0r, b0i, b1r, b1i);
    chk("s1.y0_r", if1.y0_r, a0r);
    chk("s1.y0_i", if1.y0_i, a0i);
    chk("s1.y1_r", if1.y1_r, a1r);
    chk("s1.y1_i", if1.y1_i, a1i);
    chk("s0.y0_r", if0.y0_r, b0r);
    chk("s0.y0_i", if0.y0_i, b0i);
    chk("s0.y1_r", if0.y1_r, b1r);
    chk("s0.y1_i", if0.y1_i, b1i);
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 20 && !if1.out_valid; i++) tick();
    chk("s1.out_valid", 16'(if1.out_valid), 16'd1);
    chk("s0.out_valid", 16'(if0.out_valid), 16'd1);
  endtask

  task automatic finish_mul(input word_t cr, ci);
    set_mul(1'b0, 16'h0, 16'h0);
    tick();
    set_mul(1'b1, cr, ci);
    tick();
    tick();
  endtask

  task automatic handshake();
    set_ordy(1'b1);
    tick();
    set_ordy(1'b0);
    chk("ov_clear", 16'(if1.out_valid | if0.out_valid), 16'd0);
    chk("rdy_idle", 16'(if1.in_ready & if0.in_ready), 16'd1);
  endtask

  initial begin
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    set_mul(1'b1, 16'h0, 16'h0);
    set_ordy(1'b0);
    tick();
    #1;
    chk("rst.in_ready", 16'(if1.in_ready), 16'd0);
    chk("rst.busy", 16'(if1.busy | if0.busy), 16'd0);
    chk("rst.err", 16'(if1.err | if0.err), 16'd0);
    chk("rst.mul_en", 16'(if1.mul_en), 16'd0);
    chk_y(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 16'(if1.in_ready), 16'd1);

    // basic op, multiplier latency 3
    tick();
    set_op(1'b1, 16'h2000, 0, 16'h4000, 0, 16'h7FFF, 0);
    tick();
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t1.mul_en", 16'(if1.mul_en), 16'd1);
    chk("t1.mul_a_r", if1.mul_a_r, 16'h7FFF);
    chk("t1.mul_b_r", if1.mul_b_r, 16'h4000);
    chk("t1.in_ready", 16'(if1.in_ready), 16'd0);
    tick();
    set_mul(1'b0, 16'h0, 16'h0);
    tick(); tick(); tick();
    set_mul(1'b1, 16'h3FFF, 16'h0);
    tick();
    tick();
    wait_ov();
    chk_y(16'h2FFF, 0, 16'hF000, 0, 16'h5FFF, 0, 16'hE001, 0);
    tick(); tick(); tick();
    chk("t1.hold_ov", 16'(if1.out_valid), 16'd1);
    chk("t1.hold_y0", if1.y0_r, 16'h2FFF);
    chk("t1.n_en", 16'(n_en1), 16'd1);
    handshake();

    // saturation / scaling of large sums
    set_op(1'b1, 16'h7000, 16'h9000, 16'h1234, 16'h5678,
           16'h1111, 16'h2222);
    tick();
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    tick();
    finish_mul(16'h4000, 16'hC000);
    wait_ov();
    chk_y(16'h5800, 16'hA800, 16'h1800, 16'hE800,
          16'h7FFF, 16'h8000, 16'h3000, 16'hD000);
    handshake();

    // multiplier busy for 5 cycles after transfer
    set_mul(1'b0, 16'h0, 16'h0);
    set_op(1'b1, 16'h0100, 16'h0200, 16'h0001, 0, 16'h0001, 0);
    tick();
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3.no_en", 16'(if1.mul_en | if0.mul_en), 16'd0);
      tick();
    end
    chk("t3.busy", 16'(if1.busy), 16'd1);
    set_mul(1'b1, 16'h0, 16'h0);
    #1;
    chk("t3.en", 16'(if1.mul_en), 16'd1);
    tick();
    chk("t3.en_once", 16'(if1.mul_en), 16'd0);
    finish_mul(16'h0, 16'h0);
    wait_ov();
    chk_y(16'h0080, 16'h0100, 16'h0080, 16'h0100,
          16'h0100, 16'h0200, 16'h0100, 16'h0200);
    chk("t3.n_en", 16'(n_en1), 16'd3);
    handshake();

    // multiplier never completes
    set_op(1'b1, 16'h1111, 0, 16'h2222, 0, 16'h3333, 0);
    tick();
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    tick();
    set_mul(1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 7; i++) tick();
    chk("t4.err_early", 16'(if1.err | if0.err), 16'd0);
    chk("t4.busy", 16'(if1.busy), 16'd1);
    tick();
    chk("t4.err1", 16'(if1.err), 16'd1);
    chk("t4.err0", 16'(if0.err), 16'd1);
    chk("t4.in_ready", 16'(if1.in_ready), 16'd1);
    chk("t4.no_ov", 16'(if1.out_valid | if0.out_valid), 16'd0);
    set_mul(1'b1, 16'h0, 16'h0);
    tick();
    chk("t4.no_ov2", 16'(if1.out_valid | if0.out_valid), 16'd0);
    set_op(1'b1, 16'h1000, 16'hF000, 0, 0, 0, 0);
    tick();
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    tick();
    finish_mul(16'h0800, 16'h0800);
    wait_ov();
    chk_y(16'h0C00, 16'hFC00, 16'h0400, 16'hF400,
          16'h1800, 16'hF800, 16'h0800, 16'hE800);
    chk("t4.err_sticky", 16'(if1.err & if0.err), 16'd1);
    chk("t4.n_en", 16'(n_en1), 16'd5);
    handshake();

    // downstream stall with a new operand waiting
    set_op(1'b1, 16'h0400, 0, 0, 0, 0, 0);
    tick();
    set_op(1'b1, 16'h0002, 16'h0004, 16'h0AAA, 16'h0BBB,
           16'h0CCC, 16'h0DDD);
    tick();
    finish_mul(16'h0200, 16'h0);
    wait_ov();
    chk_y(16'h0300, 0, 16'h0100, 0, 16'h0600, 0, 16'h0200, 0);
    hold = if1.y0_r;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5.stable", if1.y0_r, hold);
      chk("t5.ov", 16'(if1.out_valid), 16'd1);
      chk("t5.in_ready", 16'(if1.in_ready), 16'd0);
    end
    chk("t5.n_en", 16'(n_en1), 16'd6);
    set_ordy(1'b1);
    #1;
    chk("t5.no_comb", 16'(if1.in_ready), 16'd0);
    tick();
    set_ordy(1'b0);
    chk("t5.idle", 16'(if1.in_ready), 16'd1);
    chk("t5.ov_clr", 16'(if1.out_valid), 16'd0);
    tick();
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    chk("t5.accepted", 16'(if1.busy), 16'd1);
    chk("t5.mul_a_r", if1.mul_a_r, 16'h0CCC);
    chk("t5.mul_b_i", if0.mul_b_i, 16'h0BBB);
    tick();
    finish_mul(16'h0, 16'h0);
    wait_ov();
    chk_y(16'h0001, 16'h0002, 16'h0001, 16'h0002,
          16'h0002, 16'h0004, 16'h0002, 16'h0004);
    handshake();

    // asynchronous reset while waiting for the product
    set_op(1'b1, 16'h0123, 0, 16'h0456, 0, 16'h0789, 0);
    tick();
    set_op(1'b0, 0, 0, 0, 0, 0, 0);
    tick();
    set_mul(1'b0, 16'h0, 16'h0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.busy", 16'(if1.busy | if0.busy), 16'd0);
    chk("t6.in_ready", 16'(if1.in_ready), 16'd0);
    chk("t6.err", 16'(if1.err | if0.err), 16'd0);
    chk("t6.mul_a_r", if1.mul_a_r, 16'h0);
    chk_y(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    set_mul(1'b1, 16'h5555, 16'h5555);
    tick();
    tick();
    tick();
    chk("t6.no_ov", 16'(if1.out_valid | if0.out_valid), 16'd0);
    chk("t6.idle", 16'(if1.in_ready), 16'd1);
    chk("t6.no_en", 16'(if1.mul_en | if0.mul_en), 16'd0);
    chk("t6.n_en", 16'(n_en0), 16'd8);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fft_bfly_ctrl.md
Name: fft_bfly_ctrl

Overview:
Radix-2 decimation-in-time butterfly that acts as the initiator for the shared complex multiplier. It accepts operand pair (A, B) and twiddle W from the FFT sequencer and drives the multiplier's enable/ready handshake to obtain P = W·B. It then emits Y0 = A+P and Y1 = A−P downstream. All data is signed two's-complement Q1.(WIDTH−1), real and imaginary parts carried separately.

Parameters:
WIDTH, 16, bit width of each real/imag component (operands, twiddle, multiplier result, outputs)
SCALE, 1, 1 = outputs arithmetic-shifted right by 1 (per-stage 1/2 scaling); 0 = unscaled, saturated to WIDTH
TIMEOUT, 64, max cycles from multiplier accept to completion before abort; range 2..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand set valid
in_ready  out  1  block can accept operand set
a_r, a_i  in  WIDTH each  operand A
b_r, b_i  in  WIDTH each  operand B
w_r, w_i  in  WIDTH each  twiddle W
mul_en  out  1  request to multiplier, single-cycle pulse
mul_ready  in  1  multiplier idle/done; low while busy
mul_a_r, mul_a_i  out  WIDTH each  multiplier operand 1 (= latched W)
mul_b_r, mul_b_i  out  WIDTH each  multiplier operand 2 (= latched B)
mul_c_r, mul_c_i  in  WIDTH each  multiplier product
out_valid  out  1  Y0/Y1 valid
out_ready  in  1  downstream accepts
y0_r, y0_i, y1_r, y1_i  out  WIDTH each  butterfly outputs
err  out  1  sticky timeout flag
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while held low then 1 in IDLE, mul_en=0, out_valid=0, err=0, busy=0, all data registers and outputs=0.
- in_ready = (state==IDLE). Transfer occurs on a clock edge with in_valid & in_ready; A, B and W are latched then. mul_a/mul_b are driven from these latches and held stable until the state returns to IDLE.
- States:
  - IDLE: on transfer go to ISSUE.
  - ISSUE: when mul_ready=1, assert mul_en for exactly one cycle, clear the timeout counter, go to WAIT_ACK. If mul_ready=0, stay with mul_en=0.
  - WAIT_ACK: wait for mul_ready=0 (multiplier accepted), then go to WAIT_DONE.
  - WAIT_DONE: wait for mul_ready=1. On that cycle, latch mul_c as P and go to CALC.
  - CALC: compute in one cycle with WIDTH+1-bit sums: s0=A+P, s1=A−P.
    - SCALE=1: y = s[WIDTH:1] (arithmetic shift, truncation toward −inf).
    - SCALE=0: y = s saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
    - Register outputs, set out_valid=1, go to OUTPUT.
  - OUTPUT: hold y* and out_valid stable until out_ready=1. On that edge clear out_valid and return to IDLE. No combinational path from out_ready to in_ready; minimum initiation interval is 5 cycles plus multiplier latency.
- Timeout: the counter increments every cycle in WAIT_ACK and WAIT_DONE. When it reaches TIMEOUT:
  - err is set (sticky; cleared only by reset);
  - the operation is dropped, no out_valid is produced, and the state returns to IDLE.
- mul_en is never asserted outside ISSUE and never on two consecutive cycles.
- Simultaneous in_valid with out_ready in OUTPUT: the input is not accepted that cycle; it is accepted next cycle in IDLE.
- Inputs are ignored while not in IDLE. mul_c is sampled only on the WAIT_DONE→CALC transition.

Test Plan:
- A=(0x2000,0), B=(0x4000,0), W=(0x7FFF,0); multiplier model with latency 3 returns P=(0x3FFF,0) → SCALE=1: Y0=(0x2FFF,0), Y1=(0xF000,0); exactly one mul_en pulse; out_valid held until out_ready.
- SCALE=0 overflow: A=(0x7000,0x9000), P=(0x4000,0xC000) → Y0=(0x7FFF,0x8000) saturated; Y1=(0x3000,0xD000).
- mul_ready held low 5 cycles after transfer → ISSUE waits, mul_en stays 0, then pulses the first cycle mul_ready=1.
- Multiplier never re-raises ready, TIMEOUT=8 → err=1 eight cycles after ack, state IDLE, in_ready=1, no out_valid; the next operation completes normally with err still 1.
- out_ready low 10 cycles with in_valid=1 → outputs stable, in_ready=0, no second mul_en; accept occurs the cycle after the out_ready handshake.
- rst_n pulsed low during WAIT_DONE → all outputs 0 immediately (asynchronous); after release in_ready=1 and a stale mul_ready rise causes no output.
